project_pwm_peripheral_trip_zone: RTL and testbench
===================================================

Name: project_pwm_peripheral_trip_zone

Overview:
Output protection stage directly downstream of the six deadband stages, ahead of the uo_out[5:0] pads. Each deadband output passes through this block unchanged during normal operation. When an external active-low fault pin qualifies, the block overrides every channel with a per-channel safe level. Release follows either a latched one-shot policy or a cycle-by-cycle policy keyed to the master counter zero event.

Parameters:
CHANNELS, 6, number of PWM channels passed through (1A,1B,2A,2B,3A,3B)
FILTER_W, 4, width of the fault qualification filter threshold and counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_pwm  in  CHANNELS  PWM inputs from the deadband stages, bit0 = 1A
i_trip_n  in  1  external fault pin, active-low, asynchronous to i_clk
i_period_zero  in  1  one-cycle pulse when the master counter equals 0
i_mode  in  2  00 disabled/pass-through, 01 one-shot (OST), 10 cycle-by-cycle (CBC), 11 treated as 01
i_filter  in  FILTER_W  consecutive synced-fault cycles required before qualifying
i_safe_level  in  CHANNELS  forced level per channel while tripped
i_clear  in  1  one-cycle software clear pulse
o_pwm  out  CHANNELS  protected PWM outputs
o_tripped  out  1  high while the override is active
o_trip_flag  out  1  sticky trip indication
o_trip_count  out  8  saturating count of trip entries

Behaviour:
- Reset is synchronous, active-high and applies to all state. After reset: state IDLE, o_pwm = 0, o_tripped = 0, o_trip_flag = 0, o_trip_count = 0, filter count = 0, both synchronizer flops = 1 (no fault).
- Synchronizer: 2-flop on i_trip_n. fault_s = ~sync2.
- Filter: cnt <= fault_s ? sat_inc(cnt) : 0. qualified = fault_s && (cnt >= i_filter). With i_filter = 0, the fault qualifies on the first synced cycle.
- State machine, states IDLE / OST / CBC:
  - IDLE -> OST when qualified && mode in {01,11}.
  - IDLE -> CBC when qualified && mode == 10.
  - Mode 00 never trips.
  - OST -> IDLE only when i_clear && !qualified. A clear while the fault is still qualified is ignored, and the state stays OST.
  - CBC -> IDLE only when i_period_zero && !qualified. i_clear has no effect in CBC.
  - Any tripped state -> IDLE when i_mode == 00 (software disable overrides).
  - Release policy follows the current state, not later mode changes between 01, 10 and 11.
- Outputs are registered from next-state: o_pwm <= (next != IDLE) ? i_safe_level : i_pwm. o_tripped <= (next != IDLE).
- Pass-through latency is 1 cycle.
- Trip latency: i_trip_n low at edge k gives forced o_pwm at edge k+2+i_filter.
- o_trip_flag is set on each IDLE->tripped transition and cleared by i_clear. If set and clear occur in the same cycle, set wins.
- o_trip_count increments on each IDLE->tripped transition and saturates at 255. It is cleared only by reset.
- A fault pulse shorter than i_filter+1 synced cycles never trips, and the filter count returns to 0.
- i_safe_level is sampled every cycle while tripped, so a change takes effect after 1 cycle.

Optional Feature:
TRIP_SOFTWARE_FORCE_EN:
- Defined: adds input port i_force_trip (1 bit). While high, it is ORed into qualified, bypassing the synchronizer and filter. It obeys the same mode, release and counting rules.
- Undefined: the port is absent and only i_trip_n can trip.

Test Plan:
- Reset, then mode=01, filter=0, i_pwm=6'b101010 -> o_pwm = 101010 one cycle later; o_tripped=0, o_trip_count=0.
- mode=01, filter=3, safe=6'b000011, i_trip_n low for 10 cycles from edge k -> o_pwm = 000011 at edge k+5; flag=1, count=1. Release pin, pulse i_clear -> pass-through one cycle later, flag=0.
- mode=01, pulse i_clear while i_trip_n still low -> stays tripped, flag remains 1. Release pin -> still tripped until a second i_clear.
- mode=10, filter=0, fault low for 3 cycles, i_period_zero pulses during and after the fault -> forced through the first pulse; pass-through resumes 1 cycle after the first i_period_zero with the fault gone.
- filter=4, i_trip_n low for 4 cycles -> no trip, count=0. mode=00 with pin low -> pass-through throughout.
- Trip 300 times -> o_trip_count = 255. Assert i_reset mid-trip -> all outputs 0 and state IDLE next cycle.

Source files
------------

// File: rtl/project_pwm_peripheral_trip_zone_if.sv
// -----------------------------------------------------------------------------
// project_pwm_peripheral_trip_zone_if
// Groups the signals between the deadband stages, the trip-zone protection
// stage and its control registers.
//   master : drives PWM inputs, fault pin, period-zero pulse and control fields
//   slave  : the protection stage, drives the protected PWM and trip status
// Optional macro TRIP_SOFTWARE_FORCE_EN adds the i_force_trip signal.
// -----------------------------------------------------------------------------
interface project_pwm_peripheral_trip_zone_if #(
   parameter int CHANNELS = 6,
   parameter int FILTER_W = 4
);
   logic [CHANNELS-1:0] i_pwm;
   logic                i_trip_n;
   logic                i_period_zero;
   logic [1:0]          i_mode;
   logic [FILTER_W-1:0] i_filter;
   logic [CHANNELS-1:0] i_safe_level;
   logic                i_clear;
`ifdef TRIP_SOFTWARE_FORCE_EN
   logic                i_force_trip;
`endif
   logic [CHANNELS-1:0] o_pwm;
   logic                o_tripped;
   logic                o_trip_flag;
   logic [7:0]          o_trip_count;

   modport master (
`ifdef TRIP_SOFTWARE_FORCE_EN
      output i_force_trip,
`endif
      output i_pwm, i_trip_n, i_period_zero, i_mode, i_filter, i_safe_level, i_clear,
      input  o_pwm, o_tripped, o_trip_flag, o_trip_count
   );

   modport slave (
`ifdef TRIP_SOFTWARE_FORCE_EN
      input  i_force_trip,
`endif
      input  i_pwm, i_trip_n, i_period_zero, i_mode, i_filter, i_safe_level, i_clear,
      output o_pwm, o_tripped, o_trip_flag, o_trip_count
   );
endinterface

// File: rtl/project_pwm_peripheral_trip_zone.sv
// -----------------------------------------------------------------------------
// project_pwm_peripheral_trip_zone
// Output protection stage between the six deadband stages and the PWM pads.
// In normal operation the deadband outputs pass through with one cycle of
// latency. A qualified active-low fault forces every channel to its safe level
// until released: one-shot (OST) releases on a software clear, cycle-by-cycle
// (CBC) releases on the master counter zero event once the fault is gone.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   tz (slave)     : i_pwm, i_trip_n, i_period_zero, i_mode, i_filter,
//                    i_safe_level, i_clear -> o_pwm, o_tripped, o_trip_flag,
//                    o_trip_count
// Optional macro TRIP_SOFTWARE_FORCE_EN: i_force_trip bypasses synchronizer
// and filter and counts as a qualified fault.
// -----------------------------------------------------------------------------
module project_pwm_peripheral_trip_zone #(
   parameter int CHANNELS = 6,
   parameter int FILTER_W = 4
) (
   input logic                                i_clk,
   input logic                                i_reset,
   project_pwm_peripheral_trip_zone_if.slave  tz
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OST  = 2'b01;
   localparam logic [1:0] ST_CBC  = 2'b10;

   logic                sync1_r;
   logic                sync2_r;
   logic                fault_s;
   logic [FILTER_W-1:0] filt_cnt_r;
   logic                qualified_s;
   logic [1:0]          state_r;
   logic [1:0]          next_s;
   logic                entry_s;
   logic                clear_ok_s;
   logic [CHANNELS-1:0] pwm_r;
   logic                tripped_r;
   logic                flag_r;
   logic [7:0]          count_r;

   function automatic logic [FILTER_W-1:0] sat_inc_filt(input logic [FILTER_W-1:0] v);
      return (v == {FILTER_W{1'b1}}) ? v : v + {{(FILTER_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [7:0] sat_inc_cnt(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign fault_s = ~sync2_r;

`ifdef TRIP_SOFTWARE_FORCE_EN
   assign qualified_s = (fault_s && (filt_cnt_r >= tz.i_filter)) || tz.i_force_trip;
`else
   assign qualified_s = fault_s && (filt_cnt_r >= tz.i_filter);
`endif

   // A clear is only honoured once the fault has stopped qualifying; while the
   // fault persists it is ignored for both the state and the sticky flag.
   assign clear_ok_s = tz.i_clear && !qualified_s;
   assign entry_s    = (state_r == ST_IDLE) && (next_s != ST_IDLE);

   // Two-flop synchronizer on the asynchronous fault pin, idle level is high.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= tz.i_trip_n;
         sync2_r <= sync1_r;
      end
   end

   // Consecutive synced-fault cycle counter used for qualification.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         filt_cnt_r <= {FILTER_W{1'b0}};
      end else if (fault_s) begin
         filt_cnt_r <= sat_inc_filt(filt_cnt_r);
      end else begin
         filt_cnt_r <= {FILTER_W{1'b0}};
      end
   end

   // Next-state decode; the release policy is fixed by the state entered.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (qualified_s && (tz.i_mode != 2'b00)) begin
               if (tz.i_mode == 2'b10) begin
                  next_s = ST_CBC;
               end else begin
                  next_s = ST_OST;
               end
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_OST: begin
            if ((tz.i_mode == 2'b00) || clear_ok_s) begin
               next_s = ST_IDLE;
            end else begin
               next_s = ST_OST;
            end
         end
         ST_CBC: begin
            if ((tz.i_mode == 2'b00) || (tz.i_period_zero && !qualified_s)) begin
               next_s = ST_IDLE;
            end else begin
               next_s = ST_CBC;
            end
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
   end

   // State register and outputs registered from the next state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r   <= ST_IDLE;
         pwm_r     <= {CHANNELS{1'b0}};
         tripped_r <= 1'b0;
      end else begin
         state_r   <= next_s;
         pwm_r     <= (next_s != ST_IDLE) ? tz.i_safe_level : tz.i_pwm;
         tripped_r <= (next_s != ST_IDLE);
      end
   end

   // Sticky flag (set beats clear) and saturating trip-entry counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         flag_r  <= 1'b0;
         count_r <= 8'd0;
      end else if (entry_s) begin
         flag_r  <= 1'b1;
         count_r <= sat_inc_cnt(count_r);
      end else if (clear_ok_s) begin
         flag_r  <= 1'b0;
         count_r <= count_r;
      end else begin
         flag_r  <= flag_r;
         count_r <= count_r;
      end
   end

   assign tz.o_pwm        = pwm_r;
   assign tz.o_tripped    = tripped_r;
   assign tz.o_trip_flag  = flag_r;
   assign tz.o_trip_count = count_r;

endmodule

// File: tb/tb_project_pwm_peripheral_trip_zone.sv
// -----------------------------------------------------------------------------
// Bench for project_pwm_peripheral_trip_zone: directed stimulus, a behavioural
// reference model updated each clock and compared every cycle, plus literal
// expectations at the points called out by the test plan.
// -----------------------------------------------------------------------------
module tb_project_pwm_peripheral_trip_zone;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   project_pwm_peripheral_trip_zone_if #(.CHANNELS(6), .FILTER_W(4)) bus ();

   project_pwm_peripheral_trip_zone #(.CHANNELS(6), .FILTER_W(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .tz      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: run = consecutive low samples of the pin; a fault is
   // qualified at an edge when the run two samples earlier exceeds the filter.
   int         run_q0, run_q1, new_run;
   bit         qual, entered;
   bit         m_trip, m_cbc, m_flag;
   int         m_count;
   logic [5:0] e_pwm;

   initial begin
      run_q0 = 0; run_q1 = 0; m_trip = 0; m_cbc = 0; m_flag = 0; m_count = 0;
      e_pwm = 6'd0;
      forever begin
         @(posedge clk);
         if (rst) begin
            run_q0 = 0; run_q1 = 0; m_trip = 0; m_cbc = 0; m_flag = 0;
            m_count = 0; e_pwm = 6'd0;
         end else begin
            qual    = (run_q1 > int'(bus.i_filter));
            new_run = bus.i_trip_n ? 0 : ((run_q0 < 1000) ? run_q0 + 1 : run_q0);
            run_q1  = run_q0;
            run_q0  = new_run;
            entered = 0;
            if (bus.i_mode == 2'b00) begin
               m_trip = 0;
            end else if (!m_trip) begin
               if (qual) begin
                  m_trip  = 1;
                  m_cbc   = (bus.i_mode == 2'b10);
                  entered = 1;
               end
            end else if (m_cbc) begin
               if (bus.i_period_zero && !qual) m_trip = 0;
            end else begin
               if (bus.i_clear && !qual) m_trip = 0;
            end
            if (entered) begin
               m_flag = 1;
               if (m_count < 255) m_count = m_count + 1;
            end else if (bus.i_clear && !qual) begin
               m_flag = 0;
            end
            e_pwm = m_trip ? bus.i_safe_level : bus.i_pwm;
         end
         @(negedge clk);
         chk("model_pwm",     32'(bus.o_pwm),        32'(e_pwm));
         chk("model_tripped", 32'(bus.o_tripped),    32'(m_trip));
         chk("model_flag",    32'(bus.o_trip_flag),  32'(m_flag));
         chk("model_count",   32'(bus.o_trip_count), 32'(m_count));
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.i_pwm = 6'd0; bus.i_trip_n = 1'b1; bus.i_period_zero = 1'b0;
      bus.i_mode = 2'b01; bus.i_filter = 4'd0; bus.i_safe_level = 6'd0;
      bus.i_clear = 1'b0;
`ifdef TRIP_SOFTWARE_FORCE_EN
      bus.i_force_trip = 1'b0;
`endif
      tick(); tick();
      chk("rst_pwm", 32'(bus.o_pwm), 32'd0);
      chk("rst_tripped", 32'(bus.o_tripped), 32'd0);
      chk("rst_flag", 32'(bus.o_trip_flag), 32'd0);
      chk("rst_count", 32'(bus.o_trip_count), 32'd0);
      rst = 1'b0;

      // Pass-through, one cycle latency.
      bus.i_pwm = 6'b101010;
      tick();
      chk("pass_pwm", 32'(bus.o_pwm), 32'(6'b101010));
      chk("pass_tripped", 32'(bus.o_tripped), 32'd0);

      // OST with filter 3: forced at edge k+5.
      bus.i_filter = 4'd3; bus.i_safe_level = 6'b000011; bus.i_pwm = 6'b111100;
      bus.i_trip_n = 1'b0;
      tick();                                  // edge k
      repeat (4) tick();                       // edge k+4
      chk("ost_k4_pass", 32'(bus.o_pwm), 32'(6'b111100));
      tick();                                  // edge k+5
      chk("ost_k5_forced", 32'(bus.o_pwm), 32'(6'b000011));
      chk("ost_flag", 32'(bus.o_trip_flag), 32'd1);
      chk("ost_count", 32'(bus.o_trip_count), 32'd1);
      repeat (4) tick();
      bus.i_trip_n = 1'b1;
      repeat (3) tick();
      chk("ost_hold", 32'(bus.o_tripped), 32'd1);
      bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
      chk("ost_release_pwm", 32'(bus.o_pwm), 32'(6'b111100));
      chk("ost_release_flag", 32'(bus.o_trip_flag), 32'd0);

      // OST clear while fault still present is ignored.
      bus.i_filter = 4'd0; bus.i_trip_n = 1'b0;
      repeat (3) tick();
      chk("ost2_tripped", 32'(bus.o_tripped), 32'd1);
      chk("ost2_count", 32'(bus.o_trip_count), 32'd2);
      bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
      chk("ost2_clear_ignored", 32'(bus.o_tripped), 32'd1);
      chk("ost2_flag_kept", 32'(bus.o_trip_flag), 32'd1);
      bus.i_trip_n = 1'b1;
      repeat (4) tick();
      chk("ost2_still_tripped", 32'(bus.o_tripped), 32'd1);
      bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
      chk("ost2_released", 32'(bus.o_tripped), 32'd0);
      chk("ost2_flag_clr", 32'(bus.o_trip_flag), 32'd0);

      // CBC: release on first period-zero after the fault has gone.
      bus.i_mode = 2'b10; bus.i_pwm = 6'b010101; bus.i_safe_level = 6'b110011;
      tick();
      bus.i_trip_n = 1'b0;
      tick(); tick(); tick();                  // edges k, k+1, k+2
      chk("cbc_forced", 32'(bus.o_pwm), 32'(6'b110011));
      bus.i_trip_n = 1'b1; bus.i_period_zero = 1'b1;
      tick();                                  // edge k+3, fault still qualified
      chk("cbc_through_pz", 32'(bus.o_tripped), 32'd1);
      bus.i_period_zero = 1'b0; bus.i_safe_level = 6'b111111;
      tick();                                  // edge k+4
      chk("cbc_safe_update", 32'(bus.o_pwm), 32'(6'b111111));
      tick();                                  // edge k+5
      chk("cbc_no_pz_hold", 32'(bus.o_tripped), 32'd1);
      bus.i_period_zero = 1'b1;
      tick();                                  // edge k+6
      bus.i_period_zero = 1'b0;
      chk("cbc_release", 32'(bus.o_pwm), 32'(6'b010101));
      chk("cbc_flag_sticky", 32'(bus.o_trip_flag), 32'd1);
      chk("cbc_count", 32'(bus.o_trip_count), 32'd3);
      bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
      chk("cbc_flag_clr", 32'(bus.o_trip_flag), 32'd0);

      // Short pulse rejected by filter 4.
      bus.i_mode = 2'b01; bus.i_filter = 4'd4; bus.i_trip_n = 1'b0;
      repeat (4) tick();
      bus.i_trip_n = 1'b1;
      repeat (6) tick();
      chk("filt_no_trip", 32'(bus.o_tripped), 32'd0);
      chk("filt_count", 32'(bus.o_trip_count), 32'd3);

      // Mode 00 never trips.
      bus.i_mode = 2'b00; bus.i_filter = 4'd0; bus.i_trip_n = 1'b0;
      bus.i_pwm = 6'b100001;
      repeat (6) tick();
      chk("mode0_tripped", 32'(bus.o_tripped), 32'd0);
      chk("mode0_pwm", 32'(bus.o_pwm), 32'(6'b100001));
      bus.i_trip_n = 1'b1;
      repeat (3) tick();

      // Software disable releases a tripped state.
      bus.i_mode = 2'b01; bus.i_trip_n = 1'b0;
      repeat (3) tick();
      chk("dis_tripped", 32'(bus.o_tripped), 32'd1);
      bus.i_mode = 2'b00;
      tick();
      chk("dis_release", 32'(bus.o_pwm), 32'(6'b100001));
      bus.i_trip_n = 1'b1;
      repeat (3) tick();
      bus.i_mode = 2'b01;

      // 300 one-shot trips: counter saturates.
      for (int n = 0; n < 300; n++) begin
         bus.i_trip_n = 1'b0; tick();
         bus.i_trip_n = 1'b1; tick(); tick();
         bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
      end
      chk("count_sat", 32'(bus.o_trip_count), 32'd255);

      // Reset in the middle of a trip.
      bus.i_trip_n = 1'b0;
      repeat (3) tick();
      chk("pre_rst_tripped", 32'(bus.o_tripped), 32'd1);
      rst = 1'b1; tick();
      chk("mid_rst_pwm", 32'(bus.o_pwm), 32'd0);
      chk("mid_rst_tripped", 32'(bus.o_tripped), 32'd0);
      chk("mid_rst_flag", 32'(bus.o_trip_flag), 32'd0);
      chk("mid_rst_count", 32'(bus.o_trip_count), 32'd0);
      rst = 1'b0; bus.i_trip_n = 1'b1;
      tick();
      chk("post_rst_pass", 32'(bus.o_pwm), 32'(6'b100001));
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
